// File: rtl/new_pe_pkg.sv
// Shared definitions for the new_pe multiply-accumulate processing element:
// default widths, FSM state type and the OFM output formatting function.
// Build option: define NEW_PE_SAT_EN for unsigned saturation of OFM;
// leave it undefined for plain truncation (modulo 2^DATA_W).
package new_pe_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 24;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } pe_state_e;

  // Reduce an accumulator value to an OFM sample of data_w bits. Works on a
  // 64-bit carrier so any DATA_W/ACC_W combination up to 64 bits can use it;
  // the caller keeps the low data_w bits of the result.
  function automatic logic [63:0] fmt_ofm(input logic [63:0] x,
                                          input int unsigned data_w);
    logic [63:0] max_v;
    max_v = (64'd1 << data_w) - 64'd1;
`ifdef NEW_PE_SAT_EN
    return (x > max_v) ? max_v : x;
`else
    return x & max_v;
`endif
  endfunction

endpackage

// File: rtl/new_pe_dot3.sv
// Combinational three-lane unsigned dot product: a1*w1 + a2*w2 + a3*w3,
// zero-extended to the accumulator width.
module new_pe_dot3
  import new_pe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic [DATA_W-1:0] i_ifm1,
  input  logic [DATA_W-1:0] i_ifm2,
  input  logic [DATA_W-1:0] i_ifm3,
  input  logic [DATA_W-1:0] i_wgt1,
  input  logic [DATA_W-1:0] i_wgt2,
  input  logic [DATA_W-1:0] i_wgt3,
  output logic [ACC_W-1:0]  o_psum
);

  logic [2*DATA_W-1:0] w_prod1;
  logic [2*DATA_W-1:0] w_prod2;
  logic [2*DATA_W-1:0] w_prod3;

  // Full-width products; each fits in 2*DATA_W bits.
  always_comb begin
    w_prod1 = i_ifm1 * i_wgt1;
    w_prod2 = i_ifm2 * i_wgt2;
    w_prod3 = i_ifm3 * i_wgt3;
  end

  // Adder tree in ACC_W so the sum of three products cannot carry out.
  always_comb begin
    o_psum = ACC_W'(w_prod1) + ACC_W'(w_prod2) + ACC_W'(w_prod3);
  end

endmodule

// File: rtl/new_pe.sv
// new_pe: three-lane unsigned multiply-accumulate processing element.
// PE_en clears the accumulator and starts a pass; PE_finish folds in the
// current products, registers the formatted result on OFM and pulses valid.
// Build option: NEW_PE_SAT_EN selects saturating OFM formatting (see new_pe_pkg).
module new_pe
  import new_pe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] IFM1,
  input  logic [DATA_W-1:0] IFM2,
  input  logic [DATA_W-1:0] IFM3,
  input  logic [DATA_W-1:0] Weight1,
  input  logic [DATA_W-1:0] Weight2,
  input  logic [DATA_W-1:0] Weight3,
  input  logic              PE_en,
  input  logic              PE_finish,
  output logic [DATA_W-1:0] OFM,
  output logic              valid
);

  pe_state_e         r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0] r_ofm;
  logic              r_valid;

  pe_state_e         w_state_nxt;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [DATA_W-1:0] w_ofm_nxt;
  logic              w_valid_nxt;
  logic [ACC_W-1:0]  w_psum;
  logic [ACC_W-1:0]  w_acc_sum;
  logic [DATA_W-1:0] w_ofm_fmt;

  new_pe_dot3 #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_dot3 (
    .i_ifm1 (IFM1),
    .i_ifm2 (IFM2),
    .i_ifm3 (IFM3),
    .i_wgt1 (Weight1),
    .i_wgt2 (Weight2),
    .i_wgt3 (Weight3),
    .o_psum (w_psum)
  );

  // Running sum including this cycle's products; wraps modulo 2^ACC_W.
  always_comb begin
    w_acc_sum = r_acc + w_psum;
    w_ofm_fmt = DATA_W'(fmt_ofm(64'(w_acc_sum), DATA_W));
  end

  // Next-state and next-output decode; PE_en has priority over PE_finish.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_ofm_nxt   = r_ofm;
    w_valid_nxt = 1'b0;
    if (PE_en) begin
      w_state_nxt = ACC;
      w_acc_nxt   = '0;
    end else begin
      unique case (r_state)
        ACC: begin
          w_acc_nxt = w_acc_sum;
          if (PE_finish) begin
            w_ofm_nxt   = w_ofm_fmt;
            w_valid_nxt = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: ;  // IDLE: accumulator and inputs are ignored
      endcase
    end
  end

  // State, accumulator and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_ofm   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_ofm   <= w_ofm_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign OFM   = r_ofm;
  assign valid = r_valid;

endmodule

// File: tb/tb_new_pe.sv
// Self-checking bench for new_pe. A reference model predicts each cycle's
// valid/OFM; expected results are queued when PE_finish is driven in ACC and
// popped when the DUT raises valid. Honours NEW_PE_SAT_EN like the RTL.
module tb_new_pe;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] ifm1, ifm2, ifm3, wgt1, wgt2, wgt3;
  logic          pe_en, pe_finish;
  logic [DW-1:0] ofm;
  logic          valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];

  bit            m_in_acc;
  logic [AW-1:0] m_acc;
  logic [DW-1:0] m_ofm;
  bit            m_valid;

  new_pe dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .IFM1      (ifm1),
    .IFM2      (ifm2),
    .IFM3      (ifm3),
    .Weight1   (wgt1),
    .Weight2   (wgt2),
    .Weight3   (wgt3),
    .PE_en     (pe_en),
    .PE_finish (pe_finish),
    .OFM       (ofm),
    .valid     (valid)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_fmt(input logic [AW-1:0] x);
`ifdef NEW_PE_SAT_EN
    if (x > AW'(255)) return 8'd255;
`endif
    return x[DW-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit rst_n_i, input bit en, input bit fin,
                      input logic [DW-1:0] a1, input logic [DW-1:0] w1,
                      input logic [DW-1:0] a2, input logic [DW-1:0] w2,
                      input logic [DW-1:0] a3, input logic [DW-1:0] w3);
    logic [AW-1:0] psum;
    logic [AW-1:0] sum;
    reset_n   = rst_n_i;
    pe_en     = en;
    pe_finish = fin;
    ifm1 = a1; wgt1 = w1;
    ifm2 = a2; wgt2 = w2;
    ifm3 = a3; wgt3 = w3;
    psum = AW'(a1) * AW'(w1) + AW'(a2) * AW'(w2) + AW'(a3) * AW'(w3);
    sum  = m_acc + psum;
    m_valid = 1'b0;
    if (!rst_n_i) begin
      m_in_acc = 1'b0;
      m_acc    = '0;
      m_ofm    = '0;
    end else if (en) begin
      m_in_acc = 1'b1;
      m_acc    = '0;
    end else if (m_in_acc) begin
      m_acc = sum;
      if (fin) begin
        m_ofm    = ref_fmt(sum);
        m_valid  = 1'b1;
        m_in_acc = 1'b0;
        exp_q.push_back(m_ofm);
      end
    end
    @(posedge clk);
    #1;
    check("valid", 32'(valid), 32'(m_valid));
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) check("sb_nonempty", 32'(exp_q.size()), 32'd1);
      else check("ofm_result", 32'(ofm), 32'(exp_q.pop_front()));
    end else begin
      check("ofm_hold", 32'(ofm), 32'(m_ofm));
    end
  endtask

  task automatic acc_cycles(input int n, input bit fin_last,
                            input logic [DW-1:0] a1, input logic [DW-1:0] w1,
                            input logic [DW-1:0] a2, input logic [DW-1:0] w2,
                            input logic [DW-1:0] a3, input logic [DW-1:0] w3);
    for (int i = 0; i < n; i++)
      step(1, 0, fin_last && (i == n - 1), a1, w1, a2, w2, a3, w3);
  endtask

  task automatic start();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic finish_zero();
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_in_acc = 1'b0;
    m_acc    = '0;
    m_ofm    = '0;
    m_valid  = 1'b0;

    // 1. Reset with busy inputs, then PE_finish in IDLE.
    step(0, 1, 1, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9);
    step(0, 0, 1, 8'd7, 8'd5, 8'd3, 8'd2, 8'd1, 8'd6);
    check("reset_ofm", 32'(ofm), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    step(1, 0, 1, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3);
    check("idle_finish_valid", 32'(valid), 32'd0);

    // 2. Four cycles of psum 25, finish with zeros -> 100.
    start();
    acc_cycles(4, 0, 8'd3, 8'd2, 8'd4, 8'd1, 8'd5, 8'd3);
    finish_zero();
    check("t2_ofm", 32'(ofm), 32'd100);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_valid_drop", 32'(valid), 32'd0);

    // 3. Finish cycle products included -> 66; IDLE holds with active inputs.
    start();
    acc_cycles(6, 1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd1);
    check("t3_ofm", 32'(ofm), 32'd66);
    acc_cycles(3, 0, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd1);
    check("t3_idle_ofm", 32'(ofm), 32'd66);

    // 4. acc = 300 -> 255 saturated or 44 truncated.
    start();
    acc_cycles(5, 0, 8'd10, 8'd1, 8'd20, 8'd1, 8'd30, 8'd1);
    finish_zero();
`ifdef NEW_PE_SAT_EN
    check("t4_ofm_sat", 32'(ofm), 32'd255);
`else
    check("t4_ofm_trunc", 32'(ofm), 32'd44);
`endif

    // Back-to-back: PE_en right after finish; previous valid still shown.
    start();
    acc_cycles(2, 1, 8'd2, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0);
    start();
    acc_cycles(1, 1, 8'd4, 8'd4, 8'd1, 8'd1, 8'd0, 8'd0);
    check("b2b_ofm", 32'(ofm), 32'd17);

    // 5. PE_en and PE_finish together mid-ACC: no valid, acc cleared.
    start();
    acc_cycles(3, 0, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9);
    step(1, 1, 1, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9);
    check("t5_no_valid", 32'(valid), 32'd0);
    step(1, 0, 1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0);
    check("t5_ofm", 32'(ofm), 32'd1);

    // 6. Reset mid-ACC, then PE_finish -> no valid, OFM 0.
    start();
    acc_cycles(3, 0, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5);
    step(0, 0, 0, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5);
    finish_zero();
    check("t6_no_valid", 32'(valid), 32'd0);
    check("t6_ofm_zero", 32'(ofm), 32'd0);

    // Full-scale: 63 cycles of max inputs plus a max finish cycle.
    start();
    acc_cycles(64, 1, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
`ifdef NEW_PE_SAT_EN
    check("t6_full_sat", 32'(ofm), 32'd255);
`else
    check("t6_full_trunc", 32'(ofm), 32'd192);
`endif

    // A few randomized passes through the model/scoreboard.
    for (int p = 0; p < 4; p++) begin
      start();
      acc_cycles(1 + $urandom_range(0, 6), 1,
                 8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom), 8'($urandom));
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
